// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - op encodings as decoded by ID (bit 1: divide, bit 0: unsigned)
//   - control FSM state encodings
//   - default operand width and the matching down-counter width
package muldiv_pkg;

  localparam int N_DEF = 32;
  localparam int CNT_W = $clog2(N_DEF);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration per step of either shift-add multiply or restoring
// divide, on unsigned N-bit magnitudes.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load_i         capture a_mag_i into the low half, b_mag_i as operand, div_i as mode
//   step_i         perform one iteration
//   div_i          1 = divide, 0 = multiply (sampled on load)
//   a_mag_i        multiplicand / dividend magnitude
//   b_mag_i        multiplier / divisor magnitude
//   acc_o          2N-bit accumulator: product, or {remainder, quotient}
module muldiv_core #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           div_i,
  input  logic [N-1:0]   a_mag_i,
  input  logic [N-1:0]   b_mag_i,
  output logic [2*N-1:0] acc_o
);

  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opd_q, opd_d;
  logic           div_q, div_d;

  logic [N:0]     mul_sum;
  logic [N:0]     rem_sh;
  logic           ge;
  logic [N-1:0]   trial;

  always_comb begin
    // Multiply: add operand into upper half when the current LSB is set,
    // then shift the whole accumulator right (carry lands in the MSB).
    mul_sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opd_q} : '0);

    // Divide: shift left by one; the partial remainder can reach N+1 bits,
    // but after a successful subtract it is always below the divisor.
    rem_sh  = acc_q[2*N-1:N-1];
    ge      = (rem_sh >= {1'b0, opd_q});
    trial   = rem_sh[N-1:0] - opd_q;

    acc_d = acc_q;
    opd_d = opd_q;
    div_d = div_q;
    if (load_i) begin
      acc_d = {{N{1'b0}}, a_mag_i};
      opd_d = b_mag_i;
      div_d = div_i;
    end else if (step_i) begin
      if (div_q) acc_d = {(ge ? trial : rem_sh[N-1:0]), acc_q[N-2:0], ge};
      else       acc_d = {mul_sum, acc_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opd_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opd_q <= opd_d;
      div_q <= div_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO.
// MULT/MULTU/DIV/DIVU take N+1 cycles after start; MTHI/MTLO write in IDLE.
// Ports:
//   clk, rst_n        pipeline clock, async active-low reset
//   flush             squash the in-flight op (HI/LO untouched)
//   start, op         launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) from IDLE
//   src_a, src_b      rs / rt operands
//   mthi, mtlo        write src_a to HI / LO (IDLE, no start)
//   hi_o, lo_o        HI / LO registers
//   busy              op in flight
//   done              one-cycle pulse while HI/LO are being written by an op
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo accepted
// S_BUSY | one radix-2 step per cycle, counter runs N-1 down to 0
// S_DONE | sign fix-up, HI/LO written at end of cycle
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] src_a,
  input  logic [N-1:0] src_b,
  input  logic         mthi,
  input  logic         mtlo,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q;
  logic [N-1:0]    a_q, b_q;
  logic [N-1:0]    hi_q, lo_q;

  logic            start_go, mt_ok;
  logic            core_load, core_step;
  logic [2*N-1:0]  acc;
  logic            sgn_q, neg_ab, neg_a;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quo, rem;
  logic [N-1:0]    res_hi, res_lo;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic sgn);
    return (sgn && v[N-1]) ? -v : v;
  endfunction

  // flush in IDLE only matters in that it blocks a simultaneous start
  assign start_go = (state_q == S_IDLE) && start && !flush;
  assign mt_ok    = (state_q == S_IDLE) && !start;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    core_load = 1'b0;
    core_step = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d   = S_BUSY;
          cnt_d     = CW'(N-1);
          core_load = 1'b1;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          core_step = 1'b1;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done    = !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  muldiv_core #(.N(N)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (core_load),
    .step_i  (core_step),
    .div_i   (op[1]),
    .a_mag_i (mag(src_a, ~op[0])),
    .b_mag_i (mag(src_b, ~op[0])),
    .acc_o   (acc)
  );

  always_comb begin
    sgn_q  = ~op_q[0];
    neg_ab = sgn_q & (a_q[N-1] ^ b_q[N-1]);
    neg_a  = sgn_q & a_q[N-1];
    prod   = neg_ab ? -acc : acc;
    quo    = neg_ab ? -acc[N-1:0] : acc[N-1:0];
    rem    = neg_a  ? -acc[2*N-1:N] : acc[2*N-1:N];
    if (!op_q[1]) begin
      res_hi = prod[2*N-1:N];
      res_lo = prod[N-1:0];
    end else if (b_q == '0) begin
      // divide by zero: all-ones quotient, dividend passes through untouched
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_go) begin
        op_q <= op;
        a_q  <= src_a;
        b_q  <= src_b;
      end
      if (done) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_ok) begin
        if (mthi) hi_q <= src_a;
        if (mtlo) lo_q <= src_a;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi_o, lo_o;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .hi_o  (hi_o),
    .lo_o  (lo_o),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic mt_write(input logic to_hi, input logic to_lo, input logic [31:0] v);
    @(negedge clk);
    mthi = to_hi; mtlo = to_lo; src_a = v;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; src_a = '0;
  endtask

  // Drives start at sample point 0 (cycle T); sample point c observes cycle T+c.
  task automatic run_op(input int id, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0; src_a = '0; src_b = '0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    chk($sformatf("v%0d_busy_cycles", id), 64'(busy_cnt), 64'd33);
    chk($sformatf("v%0d_done_cycle", id), 64'(done_cyc), 64'd33);
    chk($sformatf("v%0d_done_pulses", id), 64'(done_cnt), 64'd1);
    chk($sformatf("v%0d_hi", id), 64'(hi_o), 64'(ehi));
    chk($sformatf("v%0d_lo", id), 64'(lo_o), 64'(elo));
  endtask

  initial begin
    int done_seen;

    vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
    vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst_n = 1'b0; flush = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // mthi/mtlo preload, then flush a DIV at T+10
    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    chk("mt_hi", 64'(hi_o), 64'h11);
    chk("mt_lo", 64'(lo_o), 64'h22);
    done_seen = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_seen++;
      if (c == 10) chk("flush_busy_T10", 64'(busy), 64'd1);
      if (c == 11) chk("flush_busy_T11", 64'(busy), 64'd0);
      flush = (c == 10);
    end
    flush = 1'b0;
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hi", 64'(hi_o), 64'h11);
    chk("flush_lo", 64'(lo_o), 64'h22);

    // start + mthi together: mthi dropped; start during BUSY: ignored
    mt_write(1'b1, 1'b0, 32'h55);
    @(negedge clk);
    start = 1'b1; mthi = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      if (c == 1) chk("start_mthi_hi", 64'(hi_o), 64'h55);
      if (c == 34) begin
        chk("busy_start_hi", 64'(hi_o), 64'd0);
        chk("busy_start_lo", 64'(lo_o), 64'd6);
        chk("busy_start_idle34", 64'(busy), 64'd0);
      end
      if (c == 35) chk("busy_start_idle35", 64'(busy), 64'd0);
      if (c == 5) begin
        start = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
      end
    end
    start = 1'b0;

    // reset in the middle of an op
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", 64'(hi_o), 64'd0);
    chk("rst_mid_lo", 64'(lo_o), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
